// File: rtl/rgb_pkg.sv
// Shared types, default parameters and step arithmetic for the RGB duty controller.
package rgb_pkg;

  typedef enum logic [1:0] {StIdle, StHold, StRpt} rpt_state_e;

  localparam int unsigned DefNumCh     = 3;
  localparam int unsigned DefWidth     = 8;
  localparam int unsigned DefStep      = 16;
  localparam int unsigned DefInit      = 48;
  localparam bit          DefSaturate  = 1'b1;
  localparam int unsigned DefRepeatDly = 50_000_000;
  localparam int unsigned DefRepeatPer = 12_500_000;

  // dir: 0 = add, 1 = subtract. Result is masked to 'width' bits.
  function automatic logic [31:0] sat_add(input logic [31:0] value, input logic [31:0] step,
                                          input logic dir, input logic saturate,
                                          input int unsigned width);
    logic [32:0] max_v;
    logic [32:0] sum;
    max_v = (33'd1 << width) - 33'd1;
    if (!dir) sum = {1'b0, value} + {1'b0, step};
    else      sum = {1'b0, value} - {1'b0, step};
    if (saturate) begin
      if (!dir && (sum > max_v))     sum = max_v;
      else if (dir && (value < step)) sum = '0;
    end
    sum = sum & max_v;
    return sum[31:0];
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Edge detection, hold-to-repeat FSM and restore gesture for one inc/dec button pair.
module btn_repeat
  import rgb_pkg::*;
#(
  parameter int unsigned REPEAT_DLY = DefRepeatDly,
  parameter int unsigned REPEAT_PER = DefRepeatPer
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sel,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic       step_inc,
  output logic       step_dec,
  output logic       restore
);

  localparam int unsigned CntMax = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] DlyLast = CntW'(REPEAT_DLY - 1);
  localparam logic [CntW-1:0] PerLast = CntW'(REPEAT_PER - 1);

  rpt_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dir_q, dir_d;
  logic            prev_inc_q, prev_dec_q;
  logic            blk_inc_q, blk_dec_q;
  logic [2:0]      sel_q;
  logic            rise_inc, rise_dec, edge_inc, edge_dec;
  logic            held, other, abort, rpt_due;

  // blk_*_q masks a button that is already high when reset releases.
  assign rise_inc = btn_inc & ~prev_inc_q & ~blk_inc_q;
  assign rise_dec = btn_dec & ~prev_dec_q & ~blk_dec_q;
  assign edge_inc = rise_inc & ~btn_dec;
  assign edge_dec = rise_dec & ~btn_inc;
  assign restore  = btn_inc & btn_dec & (rise_inc | rise_dec);

  assign held    = dir_q ? btn_dec : btn_inc;
  assign other   = dir_q ? btn_inc : btn_dec;
  assign abort   = ~held | other | (sel != sel_q);
  assign rpt_due = ~abort & (((state_q == StHold) && (cnt_q == DlyLast)) ||
                             ((state_q == StRpt) && (cnt_q == PerLast)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_inc_q <= 1'b0;
      prev_dec_q <= 1'b0;
      blk_inc_q  <= 1'b1;
      blk_dec_q  <= 1'b1;
      sel_q      <= '0;
    end else begin
      prev_inc_q <= btn_inc;
      prev_dec_q <= btn_dec;
      blk_inc_q  <= blk_inc_q & btn_inc;
      blk_dec_q  <= blk_dec_q & btn_dec;
      sel_q      <= sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    if (edge_inc | edge_dec) begin
      state_d = StHold;
      cnt_d   = '0;
      dir_d   = edge_dec;
    end else begin
      unique case (state_q)
        StIdle: begin
        end
        StHold, StRpt: begin
          if (abort) begin
            state_d = StIdle;
          end else if (rpt_due) begin
            state_d = StRpt;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // A fresh edge command takes precedence over a coincident repeat step.
  always_comb begin
    step_inc = 1'b0;
    step_dec = 1'b0;
    if (edge_inc | edge_dec) begin
      step_inc = edge_inc;
      step_dec = edge_dec;
    end else if (rpt_due) begin
      step_inc = ~dir_q;
      step_dec = dir_q;
    end
  end

endmodule

// File: rtl/rgb_duty_ctrl.sv
// Per-channel PWM duty register file stepped by debounced buttons, with status LED outputs.
module rgb_duty_ctrl
  import rgb_pkg::*;
#(
  parameter int unsigned NUM_CH     = DefNumCh,
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned STEP       = DefStep,
  parameter int unsigned INIT       = DefInit,
  parameter bit          SATURATE   = DefSaturate,
  parameter int unsigned REPEAT_DLY = DefRepeatDly,
  parameter int unsigned REPEAT_PER = DefRepeatPer
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              sel,
  input  logic                    btn_en,
  input  logic                    btn_inc,
  input  logic                    btn_dec,
  output logic [NUM_CH*WIDTH-1:0] duty_out,
  output logic                    led_enable,
  output logic [3:0]              led
);

  localparam logic [2:0]       NumChSel = 3'(NUM_CH);
  localparam logic [WIDTH-1:0] InitVal  = WIDTH'(INIT);
  localparam logic [31:0]      StepVal  = 32'(STEP);

  logic [WIDTH-1:0] duty_q [NUM_CH];
  logic             sel_valid;
  logic             step_inc, step_dec, restore;

  assign sel_valid = (sel != 3'd0) && (sel <= NumChSel);

  btn_repeat #(
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) u_btn_repeat (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .btn_inc  (btn_inc),
    .btn_dec  (btn_dec),
    .step_inc (step_inc),
    .step_dec (step_dec),
    .restore  (restore)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) duty_q[c] <= InitVal;
    end else if (sel_valid) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (sel == 3'(c + 1)) begin
          if (restore) begin
            duty_q[c] <= InitVal;
          end else if (step_inc | step_dec) begin
            duty_q[c] <= WIDTH'(sat_add(32'(duty_q[c]), StepVal, step_dec, SATURATE, WIDTH));
          end
        end
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_duty_out
    assign duty_out[c*WIDTH +: WIDTH] = duty_q[c];
  end

  assign led_enable = (sel == 3'd0) & btn_en;

  always_comb begin
    led = 4'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel_valid && (sel == 3'(c + 1))) led = duty_q[c][WIDTH-1 -: 4];
    end
  end

endmodule

// File: tb/tb_rgb_duty_ctrl.sv
// Bench for rgb_duty_ctrl: directed vectors, corner sequences and random stimulus vs a model.
module tb_rgb_duty_ctrl;

  localparam int unsigned NumCh = 3;
  localparam int unsigned Width = 8;
  localparam int unsigned Step  = 16;
  localparam int unsigned Init  = 48;
  localparam int unsigned Dly   = 8;
  localparam int unsigned Per   = 4;
  localparam int          MaxV  = (1 << Width) - 1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [2:0]             sel = 3'd0;
  logic                   btn_en = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
  logic [NumCh*Width-1:0] duty_sat, duty_wrap;
  logic                   len_sat, len_wrap;
  logic [3:0]             led_sat, led_wrap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rgb_duty_ctrl #(
    .NUM_CH(NumCh), .WIDTH(Width), .STEP(Step), .INIT(Init), .SATURATE(1'b1),
    .REPEAT_DLY(Dly), .REPEAT_PER(Per)
  ) dut_sat (
    .clk(clk), .rst(rst), .sel(sel), .btn_en(btn_en), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .duty_out(duty_sat), .led_enable(len_sat), .led(led_sat)
  );

  rgb_duty_ctrl #(
    .NUM_CH(NumCh), .WIDTH(Width), .STEP(Step), .INIT(Init), .SATURATE(1'b0),
    .REPEAT_DLY(Dly), .REPEAT_PER(Per)
  ) dut_wrap (
    .clk(clk), .rst(rst), .sel(sel), .btn_en(btn_en), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .duty_out(duty_wrap), .led_enable(len_wrap), .led(led_wrap)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: index 0 = saturating instance, 1 = wrapping instance.
  int         m_duty [2][NumCh];
  bit         m_valid = 1'b0;
  bit         m_prev_inc, m_prev_dec, m_wait_inc, m_wait_dec, m_holding, m_hold_dec;
  int         m_t0, m_cyc = 0, m_el;
  logic [2:0] m_prev_sel;
  bit         r_inc, r_dec, do_step, do_dec, do_restore, give_up;

  function automatic int apply_step(input int v, input bit dec, input bit sat);
    int r;
    r = dec ? v - int'(Step) : v + int'(Step);
    if (sat) begin
      if (r < 0) r = 0;
      if (r > MaxV) r = MaxV;
    end else begin
      r = (r + MaxV + 1) % (MaxV + 1);
    end
    return r;
  endfunction

  always @(posedge clk) begin
    m_cyc++;
    if (!rst) begin
      for (int k = 0; k < 2; k++) for (int c = 0; c < NumCh; c++) m_duty[k][c] = Init;
      m_prev_inc = 0; m_prev_dec = 0; m_wait_inc = 1; m_wait_dec = 1;
      m_holding  = 0; m_prev_sel = 3'd0; m_valid = 1;
    end else begin
      r_inc      = btn_inc && !m_prev_inc && !m_wait_inc;
      r_dec      = btn_dec && !m_prev_dec && !m_wait_dec;
      do_step    = 0;
      do_dec     = 0;
      do_restore = btn_inc && btn_dec && (r_inc || r_dec);
      if (r_inc && !btn_dec) begin
        do_step = 1; do_dec = 0; m_holding = 1; m_hold_dec = 0; m_t0 = m_cyc;
      end else if (r_dec && !btn_inc) begin
        do_step = 1; do_dec = 1; m_holding = 1; m_hold_dec = 1; m_t0 = m_cyc;
      end else if (m_holding) begin
        give_up = m_hold_dec ? (!btn_dec || btn_inc) : (!btn_inc || btn_dec);
        if (give_up || sel != m_prev_sel) begin
          m_holding = 0;
        end else begin
          m_el = m_cyc - m_t0;
          if (m_el == int'(Dly) || (m_el > int'(Dly) && (m_el - int'(Dly)) % int'(Per) == 0)) begin
            do_step = 1; do_dec = m_hold_dec;
          end
        end
      end
      if (sel >= 3'd1 && sel <= 3'(NumCh)) begin
        for (int k = 0; k < 2; k++) begin
          if (do_restore)   m_duty[k][sel-1] = Init;
          else if (do_step) m_duty[k][sel-1] = apply_step(m_duty[k][sel-1], do_dec, k == 0);
        end
      end
      m_prev_inc = btn_inc;
      m_prev_dec = btn_dec;
      if (!btn_inc) m_wait_inc = 0;
      if (!btn_dec) m_wait_dec = 0;
      m_prev_sel = sel;
    end
  end

  always @(negedge clk) begin
    logic [NumCh*Width-1:0] e0, e1;
    logic [3:0]             el0, el1;
    if (m_valid) begin
      el0 = 4'd0;
      el1 = 4'd0;
      for (int c = 0; c < NumCh; c++) begin
        e0[c*Width +: Width] = Width'(m_duty[0][c]);
        e1[c*Width +: Width] = Width'(m_duty[1][c]);
      end
      if (sel >= 3'd1 && sel <= 3'(NumCh)) begin
        el0 = 4'(m_duty[0][sel-1] >> (Width - 4));
        el1 = 4'(m_duty[1][sel-1] >> (Width - 4));
      end
      check("model duty sat", 32'(duty_sat), 32'(e0));
      check("model duty wrap", 32'(duty_wrap), 32'(e1));
      check("model led sat", 32'(led_sat), 32'(el0));
      check("model led wrap", 32'(led_wrap), 32'(el1));
      check("model led_enable", 32'(len_sat), 32'((sel == 3'd0) && btn_en));
    end
  end

  typedef struct {
    logic [2:0] sel;
    logic       en, inc, dec;
    int         c0, c1, c2;
    logic [3:0] led;
    logic       len;
  } vec_t;

  vec_t vecs [22];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{3'd1, 0, 0, 0, 48, 48, 48, 4'd3, 0};
    vecs[1]  = '{3'd1, 0, 1, 0, 64, 48, 48, 4'd4, 0};
    vecs[2]  = '{3'd1, 0, 0, 0, 64, 48, 48, 4'd4, 0};
    vecs[3]  = '{3'd1, 0, 0, 1, 48, 48, 48, 4'd3, 0};
    vecs[4]  = '{3'd1, 0, 0, 0, 48, 48, 48, 4'd3, 0};
    vecs[5]  = '{3'd1, 0, 1, 0, 64, 48, 48, 4'd4, 0};
    vecs[6]  = '{3'd1, 0, 0, 0, 64, 48, 48, 4'd4, 0};
    vecs[7]  = '{3'd1, 0, 1, 0, 80, 48, 48, 4'd5, 0};
    vecs[8]  = '{3'd1, 0, 0, 0, 80, 48, 48, 4'd5, 0};
    vecs[9]  = '{3'd1, 0, 1, 0, 96, 48, 48, 4'd6, 0};
    vecs[10] = '{3'd1, 0, 0, 0, 96, 48, 48, 4'd6, 0};
    vecs[11] = '{3'd1, 0, 1, 1, 48, 48, 48, 4'd3, 0};
    vecs[12] = '{3'd1, 0, 0, 0, 48, 48, 48, 4'd3, 0};
    vecs[13] = '{3'd0, 1, 0, 0, 48, 48, 48, 4'd0, 1};
    vecs[14] = '{3'd0, 1, 1, 1, 48, 48, 48, 4'd0, 1};
    vecs[15] = '{3'd0, 1, 0, 0, 48, 48, 48, 4'd0, 1};
    vecs[16] = '{3'd0, 0, 1, 0, 48, 48, 48, 4'd0, 0};
    vecs[17] = '{3'd0, 0, 0, 0, 48, 48, 48, 4'd0, 0};
    vecs[18] = '{3'd5, 0, 1, 0, 48, 48, 48, 4'd0, 0};
    vecs[19] = '{3'd5, 0, 0, 0, 48, 48, 48, 4'd0, 0};
    vecs[20] = '{3'd2, 0, 0, 1, 48, 32, 48, 4'd2, 0};
    vecs[21] = '{3'd2, 0, 0, 0, 48, 32, 48, 4'd2, 0};

    rst = 1'b0;
    repeat (3) cyc();
    check("reset duty", 32'(duty_sat), 32'({3{8'd48}}));
    rst = 1'b1;

    foreach (vecs[i]) begin
      sel = vecs[i].sel; btn_en = vecs[i].en; btn_inc = vecs[i].inc; btn_dec = vecs[i].dec;
      cyc();
      check($sformatf("vec%0d ch0", i), 32'(duty_sat[0 +: 8]), 32'(vecs[i].c0));
      check($sformatf("vec%0d ch1", i), 32'(duty_sat[8 +: 8]), 32'(vecs[i].c1));
      check($sformatf("vec%0d ch2", i), 32'(duty_sat[16 +: 8]), 32'(vecs[i].c2));
      check($sformatf("vec%0d wrap", i), 32'(duty_wrap), 32'(duty_sat));
      check($sformatf("vec%0d led", i), 32'(led_sat), 32'(vecs[i].led));
      check($sformatf("vec%0d led_enable", i), 32'(len_sat), 32'(vecs[i].len));
    end
    btn_en = 1'b0;

    // Hold-to-repeat on channel 1 after restoring it.
    sel = 3'd2; btn_inc = 1; btn_dec = 1; cyc();
    btn_inc = 0; btn_dec = 0; cyc();
    check("hold start ch1", 32'(duty_sat[8 +: 8]), 32'd48);
    btn_inc = 1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      check($sformatf("hold k%0d ch1", k), 32'(duty_sat[8 +: 8]),
            32'(48 + 16 * (1 + int'(k >= 8) + int'(k >= 12) + int'(k >= 16))));
    end
    btn_inc = 0;
    repeat (10) cyc();
    check("hold released ch1", 32'(duty_sat[8 +: 8]), 32'd112);

    // Restore gesture held long: back to INIT, and no repeat follows.
    sel = 3'd1;
    for (int k = 0; k < 3; k++) begin btn_inc = 1; cyc(); btn_inc = 0; cyc(); end
    check("pre-restore ch0", 32'(duty_sat[0 +: 8]), 32'd96);
    btn_inc = 1; btn_dec = 1;
    for (int k = 0; k < 12; k++) begin
      cyc();
      check($sformatf("restore k%0d ch0", k), 32'(duty_sat[0 +: 8]), 32'd48);
    end
    btn_inc = 0; btn_dec = 0; cyc();

    // Saturation vs wrap on channel 2.
    sel = 3'd3;
    for (int i = 1; i <= 14; i++) begin
      btn_inc = 1; cyc(); btn_inc = 0; cyc();
      check($sformatf("sat pulse%0d", i), 32'(duty_sat[16 +: 8]),
            32'((48 + 16 * i > 255) ? 255 : 48 + 16 * i));
      check($sformatf("wrap pulse%0d", i), 32'(duty_wrap[16 +: 8]), 32'((48 + 16 * i) % 256));
    end
    check("sat led", 32'(led_sat), 32'd15);
    check("wrap led", 32'(led_wrap), 32'd1);

    // Reset mid-hold, button still held after reset release.
    sel = 3'd1; btn_inc = 1;
    repeat (12) cyc();
    check("pre-reset ch0", 32'(duty_sat[0 +: 8]), 32'd80);
    rst = 0;
    repeat (2) cyc();
    check("mid-hold reset sat", 32'(duty_sat), 32'({3{8'd48}}));
    check("mid-hold reset wrap", 32'(duty_wrap), 32'({3{8'd48}}));
    rst = 1;
    for (int k = 0; k < 15; k++) begin
      cyc();
      check($sformatf("post-reset held k%0d", k), 32'(duty_sat[0 +: 8]), 32'd48);
    end
    btn_inc = 0; cyc();
    btn_inc = 1; cyc();
    check("fresh press ch0", 32'(duty_sat[0 +: 8]), 32'd64);
    btn_inc = 0; cyc();

    // Random stimulus; the model checker compares every cycle.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 5) == 0)   btn_inc = ~btn_inc;
      if ($urandom_range(0, 7) == 0)   btn_dec = ~btn_dec;
      if ($urandom_range(0, 39) == 0)  sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0)   btn_en = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      cyc();
    end
    rst = 1; btn_inc = 0; btn_dec = 0;
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
